// File: rtl/drp_seq_pkg.sv
// rtl/drp_seq_pkg.sv - shared types and helpers for the DRP read-modify-write sequencer
package drp_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_ACCESS,
        WR_SETUP,
        WR_ACCESS,
        NEXT,
        FINISH
    } drp_seq_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_SLVERR  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // Replace the masked field of a DRP word, keep every other bit.
    function automatic logic [15:0] drp_rmw(input logic [15:0] old,
                                            input logic [15:0] mask,
                                            input logic [15:0] val);
        return (old & ~mask) | (val & mask);
    endfunction

endpackage

// File: rtl/apb_drp_rmw_sequencer.sv
// rtl/apb_drp_rmw_sequencer.sv - table-driven APB read-modify-write sequencer for one DRP window
module apb_drp_rmw_sequencer
    import drp_seq_pkg::*;
#(
    parameter int NUM_OPS    = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 1023,
    parameter logic [NUM_OPS*ADDR_WIDTH-1:0] OP_ADDR = '0,
    parameter logic [NUM_OPS*16-1:0]         OP_MASK = '0,
    parameter logic [NUM_OPS*16-1:0]         OP_VAL0 = '0,
    parameter logic [NUM_OPS*16-1:0]         OP_VAL1 = '0
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  start,
    input  logic                  cfg_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [3:0]            err_index,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [31:0]           pwdata,
    output logic [3:0]            pstrb,
    input  logic [31:0]           prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam logic [3:0]   LAST_IDX = 4'(NUM_OPS - 1);
    localparam int           TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    drp_seq_state_t state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic           sel_q, sel_d;
    logic           failed_q, failed_d;
    logic [15:0]    wdata_q, wdata_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic [1:0]     code_d;
    logic [3:0]     index_d;

    // DRP data is only 16 bits wide; the upper half of the bus carries nothing.
    logic unused_prdata_hi;
    assign unused_prdata_hi = ^prdata[31:16];

    function automatic logic [ADDR_WIDTH-1:0] op_addr(input logic [3:0] i);
        return OP_ADDR[int'(i)*ADDR_WIDTH +: ADDR_WIDTH];
    endfunction

    function automatic logic [15:0] op_mask(input logic [3:0] i);
        return OP_MASK[int'(i)*16 +: 16];
    endfunction

    function automatic logic [15:0] op_val(input logic [3:0] i, input logic sel);
        return sel ? OP_VAL1[int'(i)*16 +: 16] : OP_VAL0[int'(i)*16 +: 16];
    endfunction

    // Next-state, table walk, write-data merge and abort bookkeeping.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sel_d    = sel_q;
        failed_d = failed_q;
        wdata_d  = wdata_q;
        tcnt_d   = tcnt_q;
        code_d   = err_code;
        index_d  = err_index;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d    = cfg_sel;
                    idx_d    = 4'd0;
                    failed_d = 1'b0;
                    code_d   = ERR_NONE;
                    index_d  = 4'd0;
                    // A full mask overwrites the whole register, so the read is skipped.
                    wdata_d  = drp_rmw(16'h0000, op_mask(4'd0), op_val(4'd0, cfg_sel));
                    state_d  = (op_mask(4'd0) == 16'hffff) ? WR_SETUP : RD_SETUP;
                end
            end
            RD_SETUP, WR_SETUP: begin
                tcnt_d  = '0;
                state_d = (state_q == RD_SETUP) ? RD_ACCESS : WR_ACCESS;
            end
            RD_ACCESS, WR_ACCESS: begin
                if (pready) begin
                    if (pslverr) begin
                        failed_d = 1'b1;
                        code_d   = ERR_SLVERR;
                        index_d  = idx_q;
                        state_d  = FINISH;
                    end else if (state_q == RD_ACCESS) begin
                        wdata_d = drp_rmw(prdata[15:0], op_mask(idx_q), op_val(idx_q, sel_q));
                        state_d = WR_SETUP;
                    end else begin
                        state_d = NEXT;
                    end
                end else if (tcnt_q == TO_LAST) begin
                    failed_d = 1'b1;
                    code_d   = ERR_TIMEOUT;
                    index_d  = idx_q;
                    state_d  = FINISH;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = FINISH;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    wdata_d = drp_rmw(16'h0000, op_mask(idx_d), op_val(idx_d, sel_q));
                    state_d = (op_mask(idx_d) == 16'hffff) ? WR_SETUP : RD_SETUP;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, run context and registered APB/status outputs.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            sel_q     <= 1'b0;
            failed_q  <= 1'b0;
            wdata_q   <= 16'h0000;
            tcnt_q    <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= 32'h0;
            pstrb     <= 4'h0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            err_index <= 4'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            failed_q  <= failed_d;
            wdata_q   <= wdata_d;
            tcnt_q    <= tcnt_d;
            psel      <= state_d inside {RD_SETUP, RD_ACCESS, WR_SETUP, WR_ACCESS};
            penable   <= state_d inside {RD_ACCESS, WR_ACCESS};
            pwrite    <= state_d inside {WR_SETUP, WR_ACCESS};
            pstrb     <= (state_d inside {WR_SETUP, WR_ACCESS}) ? 4'hf : 4'h0;
            if (state_d inside {RD_SETUP, WR_SETUP}) begin
                paddr <= op_addr(idx_d);
            end
            if (state_d == WR_SETUP) begin
                pwdata <= {16'h0000, wdata_d};
            end
            busy      <= state_d inside {RD_SETUP, RD_ACCESS, WR_SETUP, WR_ACCESS, NEXT};
            done      <= (state_d == FINISH) && !failed_d;
            err       <= (state_d == FINISH) && failed_d;
            err_code  <= code_d;
            err_index <= index_d;
        end
    end

endmodule

// File: tb/tb_apb_drp_rmw_sequencer.sv
// tb/tb_apb_drp_rmw_sequencer.sv - directed self-checking bench for apb_drp_rmw_sequencer
module tb_apb_drp_rmw_sequencer;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic        start [2];
    logic        cfg_sel [2];
    logic        busy [2];
    logic        done [2];
    logic        err [2];
    logic [1:0]  err_code [2];
    logic [3:0]  err_index [2];
    logic [9:0]  paddr [2];
    logic        psel [2];
    logic        penable [2];
    logic        pwrite [2];
    logic [31:0] pwdata [2];
    logic [3:0]  pstrb [2];
    logic [31:0] prdata [2];
    logic        pready [2];
    logic        pslverr [2];

    logic        hang [2];
    logic        slv_en [2];
    logic [45:0] wlog0 [$];
    logic [45:0] wlog1 [$];
    int          rd_cnt [2] = '{0, 0};

    int n_total = 0;
    int n_bad   = 0;

    always #5 pclk = ~pclk;

    // dut0: two read-modify-write ops
    apb_drp_rmw_sequencer #(
        .NUM_OPS(2), .ADDR_WIDTH(10), .TIMEOUT(15),
        .OP_ADDR({10'h020, 10'h010}),
        .OP_MASK({16'h0f00, 16'h00f0}),
        .OP_VAL0({16'h0300, 16'h0050}),
        .OP_VAL1({16'h0c00, 16'h00a0})
    ) dut0 (
        .pclk(pclk), .preset_n(preset_n), .start(start[0]), .cfg_sel(cfg_sel[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0]), .err_code(err_code[0]),
        .err_index(err_index[0]), .paddr(paddr[0]), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]), .prdata(prdata[0]),
        .pready(pready[0]), .pslverr(pslverr[0])
    );

    // dut1: op0 read-modify-write, op1 full-mask write-only
    apb_drp_rmw_sequencer #(
        .NUM_OPS(2), .ADDR_WIDTH(10),
        .OP_ADDR({10'h024, 10'h010}),
        .OP_MASK({16'hffff, 16'h00f0}),
        .OP_VAL0({16'h1111, 16'h0050}),
        .OP_VAL1({16'hbeef, 16'h00a0})
    ) dut1 (
        .pclk(pclk), .preset_n(preset_n), .start(start[1]), .cfg_sel(cfg_sel[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1]), .err_code(err_code[1]),
        .err_index(err_index[1]), .paddr(paddr[1]), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]), .prdata(prdata[1]),
        .pready(pready[1]), .pslverr(pslverr[1])
    );

    function automatic logic [31:0] rdval(input logic [9:0] a);
        case (a)
            10'h010: return 32'h0000_1234;
            10'h020: return 32'h0000_a5a5;
            default: return 32'hdead_0000;
        endcase
    endfunction

    // Zero-wait-state completers; hang withholds pready, slv_en fails writes to 0x024.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            pready[k]  = psel[k] & penable[k] & ~hang[k];
            pslverr[k] = pready[k] & pwrite[k] & slv_en[k] & (paddr[k] == 10'h024);
            prdata[k]  = rdval(paddr[k]);
        end
    end

    // Log completed transfers.
    always @(posedge pclk) begin
        if (psel[0] && penable[0] && pready[0]) begin
            if (pwrite[0]) begin
                if (!pslverr[0]) wlog0.push_back({pstrb[0], paddr[0], pwdata[0]});
            end else begin
                rd_cnt[0] <= rd_cnt[0] + 1;
            end
        end
        if (psel[1] && penable[1] && pready[1]) begin
            if (pwrite[1]) begin
                if (!pslverr[1]) wlog1.push_back({pstrb[1], paddr[1], pwdata[1]});
            end else begin
                rd_cnt[1] <= rd_cnt[1] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run(input int i, input logic sel, input int mid,
                       output int cyc, output int acc, output logic first_psel,
                       output logic got_done, output logic got_err);
        @(negedge pclk);
        start[i]   = 1'b1;
        cfg_sel[i] = sel;
        @(negedge pclk);
        start[i]   = 1'b0;
        first_psel = psel[i] & ~penable[i];
        cyc = 0; acc = 0; got_done = 1'b0; got_err = 1'b0;
        for (int g = 0; g < 300; g++) begin
            if (done[i]) begin got_done = 1'b1; break; end
            if (err[i])  begin got_err  = 1'b1; break; end
            if (busy[i]) cyc++;
            if (psel[i] && penable[i]) acc++;
            start[i] = (mid != 0 && cyc == mid);
            @(negedge pclk);
        end
        start[i] = 1'b0;
    endtask

    int   cyc, acc, base, rbase, seen;
    logic fp, gd, ge;

    initial begin
        preset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; cfg_sel[k] = 1'b0; hang[k] = 1'b0; slv_en[k] = 1'b0;
        end
        repeat (3) @(negedge pclk);
        check("rst psel",      64'(psel[0]),      64'd0);
        check("rst penable",   64'(penable[0]),   64'd0);
        check("rst busy",      64'(busy[0]),      64'd0);
        check("rst done/err",  64'({done[0], err[0]}), 64'd0);
        check("rst err_code",  64'(err_code[0]),  64'd0);
        check("rst paddr",     64'(paddr[0]),     64'd0);
        check("rst pstrb",     64'(pstrb[0]),     64'd0);
        preset_n = 1'b1;
        repeat (2) @(negedge pclk);

        // Two RMW ops, cfg_sel=0
        base = wlog0.size(); rbase = rd_cnt[0];
        run(0, 1'b0, 0, cyc, acc, fp, gd, ge);
        check("rmw done",       64'(gd),  64'd1);
        check("rmw cycles",     64'(cyc), 64'd10);
        check("rmw first psel", 64'(fp),  64'd1);
        check("rmw reads",      64'(rd_cnt[0] - rbase), 64'd2);
        check("rmw writes",     64'(wlog0.size() - base), 64'd2);
        check("rmw wr0",        64'(wlog0[base]),     {18'h0, 4'hf, 10'h010, 32'h0000_1254});
        check("rmw wr1",        64'(wlog0[base + 1]), {18'h0, 4'hf, 10'h020, 32'h0000_a3a5});
        check("rmw err_code",   64'(err_code[0]), 64'd0);

        // Full-mask op1 skips its read, cfg_sel=1
        base = wlog1.size(); rbase = rd_cnt[1];
        run(1, 1'b1, 0, cyc, acc, fp, gd, ge);
        check("wo done",   64'(gd),  64'd1);
        check("wo cycles", 64'(cyc), 64'd8);
        check("wo reads",  64'(rd_cnt[1] - rbase), 64'd1);
        check("wo writes", 64'(wlog1.size() - base), 64'd2);
        check("wo wr0",    64'(wlog1[base]),     {18'h0, 4'hf, 10'h010, 32'h0000_12a4});
        check("wo wr1",    64'(wlog1[base + 1]), {18'h0, 4'hf, 10'h024, 32'h0000_beef});

        // pslverr on op1 write
        slv_en[1] = 1'b1;
        base = wlog1.size();
        run(1, 1'b0, 0, cyc, acc, fp, gd, ge);
        check("slv err",       64'(ge),  64'd1);
        check("slv done",      64'(gd),  64'd0);
        check("slv err_code",  64'(err_code[1]),  64'd1);
        check("slv err_index", 64'(err_index[1]), 64'd1);
        check("slv psel",      64'(psel[1]),      64'd0);
        check("slv busy",      64'(busy[1]),      64'd0);
        check("slv writes",    64'(wlog1.size() - base), 64'd1);
        @(negedge pclk);
        check("slv err pulse", 64'(err[1]),      64'd0);
        check("slv code held", 64'(err_code[1]), 64'd1);
        slv_en[1] = 1'b0;

        // Completer never ready
        hang[0] = 1'b1;
        run(0, 1'b0, 0, cyc, acc, fp, gd, ge);
        check("to err",       64'(ge),  64'd1);
        check("to access",    64'(acc), 64'd15);
        check("to err_code",  64'(err_code[0]),  64'd2);
        check("to err_index", 64'(err_index[0]), 64'd0);
        check("to psel",      64'(psel[0]),      64'd0);
        hang[0] = 1'b0;

        // start while busy and in the done cycle is ignored
        base = wlog0.size();
        run(0, 1'b0, 3, cyc, acc, fp, gd, ge);
        check("ign done",     64'(gd),  64'd1);
        check("ign cycles",   64'(cyc), 64'd10);
        check("ign code clr", 64'(err_code[0]), 64'd0);
        start[0] = 1'b1;
        @(negedge pclk);
        start[0] = 1'b0;
        seen = 0;
        for (int g = 0; g < 20; g++) begin
            if (busy[0] || psel[0]) seen++;
            @(negedge pclk);
        end
        check("ign no rerun", 64'(seen), 64'd0);
        check("ign writes",   64'(wlog0.size() - base), 64'd2);

        // Reset during op0 RD_ACCESS
        @(negedge pclk);
        start[0] = 1'b1; cfg_sel[0] = 1'b1;
        @(negedge pclk);
        start[0] = 1'b0;
        seen = 0;
        for (int g = 0; g < 10 && !(psel[0] && penable[0]); g++) @(negedge pclk);
        check("rstmid in access", 64'(psel[0] & penable[0] & ~pwrite[0]), 64'd1);
        #2 preset_n = 1'b0;
        #1;
        check("rstmid psel",    64'(psel[0]),    64'd0);
        check("rstmid penable", 64'(penable[0]), 64'd0);
        check("rstmid busy",    64'(busy[0]),    64'd0);
        @(negedge pclk);
        preset_n = 1'b1;
        base = wlog0.size();
        run(0, 1'b1, 0, cyc, acc, fp, gd, ge);
        check("rerun done",   64'(gd),  64'd1);
        check("rerun cycles", 64'(cyc), 64'd10);
        check("rerun writes", 64'(wlog0.size() - base), 64'd2);
        check("rerun wr0",    64'(wlog0[base]),     {18'h0, 4'hf, 10'h010, 32'h0000_12a4});
        check("rerun wr1",    64'(wlog0[base + 1]), {18'h0, 4'hf, 10'h020, 32'h0000_aca5});

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
